// File: rtl/ms_tick_gen.sv
// ms_tick_gen: stopwatch front end. Conditions the raw start/stop/clear
// buttons (2-FF sync, debounce, rising-edge event), runs the IDLE/RUN/PAUSED
// control FSM and divides clk down to a one-cycle millisecond strobe.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst        asynchronous active-low reset
//   btn_start  raw start button (async, active-high)
//   btn_stop   raw stop button (async, active-high)
//   btn_clear  raw clear button (async, active-high)
//   ms         one-cycle strobe every DIV cycles while running
//   clr        one-cycle strobe on an accepted clear event
//   running    1 while in RUN
//   paused     1 while in PAUSED
module ms_tick_gen #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned TICK_HZ     = 1000,
    parameter int unsigned DIV_W       = 32,
    parameter int unsigned DEB_CYCLES  = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_start,
    input  logic btn_stop,
    input  logic btn_clear,
    output logic ms,
    output logic clr,
    output logic running,
    output logic paused
);

    localparam int unsigned DIV   = CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned NBTN  = 3;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2
    } state_t;

    // Button index: 0 = start, 1 = stop, 2 = clear
    logic [NBTN-1:0]  btn_raw;
    logic [NBTN-1:0]  sync1;
    logic [NBTN-1:0]  sync2;
    logic [NBTN-1:0]  deb;
    logic [NBTN-1:0]  armed;
    logic [NBTN-1:0]  ev;
    logic [DEB_W-1:0] deb_cnt [NBTN];
    logic [1:0]       prime_cnt;

    logic ev_start;
    logic ev_stop;
    logic ev_clear;

    state_t           state;
    logic [DIV_W-1:0] div;

    assign btn_raw  = {btn_clear, btn_stop, btn_start};
    assign ev_start = ev[0];
    assign ev_stop  = ev[1];
    assign ev_clear = ev[2];

    // Input conditioning. prime_cnt marks when sync2 first reflects the real
    // pin after reset; a button is armed only once it has been seen released,
    // so a button held through reset cannot fire until it is pressed again.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= '0;
            sync2     <= '0;
            deb       <= '0;
            armed     <= '0;
            ev        <= '0;
            prime_cnt <= '0;
            for (int i = 0; i < int'(NBTN); i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            if (prime_cnt != 2'd2) begin
                prime_cnt <= prime_cnt + 2'd1;
            end
            for (int i = 0; i < int'(NBTN); i++) begin
                ev[i] <= 1'b0;
                if (prime_cnt == 2'd2 && !sync2[i]) begin
                    armed[i] <= 1'b1;
                end
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    // Level accepted; only a 0->1 acceptance is an event
                    deb_cnt[i] <= '0;
                    deb[i]     <= sync2[i];
                    ev[i]      <= sync2[i] & armed[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    // Control FSM and tick divider. Clear beats stop beats start; running and
    // paused are registered alongside state so they always agree with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            div     <= '0;
            ms      <= 1'b0;
            clr     <= 1'b0;
            running <= 1'b0;
            paused  <= 1'b0;
        end else begin
            ms  <= 1'b0;
            clr <= 1'b0;
            if (ev_clear) begin
                state   <= S_IDLE;
                div     <= '0;
                clr     <= 1'b1;
                running <= 1'b0;
                paused  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        div <= '0;
                        if (ev_start && !ev_stop) begin
                            state   <= S_RUN;
                            running <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (ev_stop) begin
                            state   <= S_PAUSED;
                            running <= 1'b0;
                            paused  <= 1'b1;
                        end else if (div == DIV_LAST) begin
                            div <= '0;
                            ms  <= 1'b1;
                        end else begin
                            div <= div + DIV_W'(1);
                        end
                    end
                    S_PAUSED: begin
                        // div holds the partial count across the pause
                        if (ev_start && !ev_stop) begin
                            state   <= S_RUN;
                            running <= 1'b1;
                            paused  <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= S_IDLE;
                        div     <= '0;
                        running <= 1'b0;
                        paused  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ms_tick_gen.sv
// tb_ms_tick_gen: directed scenarios followed by random button traffic,
// compared every cycle against a stopwatch reference model.
module tb_ms_tick_gen;

    localparam int DIV = 10;
    localparam int DEB = 3;
    localparam int IDLE = 0;
    localparam int RUN = 1;
    localparam int PAUSED = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_start = 1'b0;
    logic btn_stop = 1'b0;
    logic btn_clear = 1'b0;
    logic ms;
    logic clr;
    logic running;
    logic paused;

    int nvec = 0;
    int nerr = 0;

    ms_tick_gen #(
        .CLK_FREQ_HZ(10),
        .TICK_HZ    (1),
        .DIV_W      (8),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_start(btn_start),
        .btn_stop (btn_stop),
        .btn_clear(btn_clear),
        .ms       (ms),
        .clr      (clr),
        .running  (running),
        .paused   (paused)
    );

    always #5 clk = ~clk;

    // Reference model: buttons as sample histories, stopwatch as elapsed
    // running cycles (a strobe whenever elapsed reaches a multiple of DIV).
    int k;
    bit deb_m [3];
    bit armed_m [3];
    bit ev_m [3];
    bit samp [3][$];
    int st_m;
    int elapsed;
    bit ms_m;
    bit clr_m;

    // Synchronized level seen by the debouncer at edge j: the pin two edges earlier
    function automatic bit synced_before(int b, int j);
        if (j >= 3) return samp[b][j-3];
        return 1'b0;
    endfunction

    task automatic model_reset();
        k = 0;
        for (int b = 0; b < 3; b++) begin
            deb_m[b] = 1'b0;
            armed_m[b] = 1'b0;
            ev_m[b] = 1'b0;
            samp[b].delete();
        end
        st_m = IDLE;
        elapsed = 0;
        ms_m = 1'b0;
        clr_m = 1'b0;
    endtask

    task automatic model_edge();
        bit cur [3];
        bit flip;
        bit new_ev;
        cur[0] = btn_start;
        cur[1] = btn_stop;
        cur[2] = btn_clear;
        k++;
        ms_m = 1'b0;
        clr_m = 1'b0;
        if (ev_m[2]) begin
            st_m = IDLE;
            elapsed = 0;
            clr_m = 1'b1;
        end else if (st_m == IDLE) begin
            if (ev_m[0] && !ev_m[1]) begin
                st_m = RUN;
                elapsed = 0;
            end
        end else if (st_m == RUN) begin
            if (ev_m[1]) begin
                st_m = PAUSED;
            end else begin
                elapsed++;
                if (elapsed % DIV == 0) ms_m = 1'b1;
            end
        end else begin
            if (ev_m[0] && !ev_m[1]) st_m = RUN;
        end
        for (int b = 0; b < 3; b++) begin
            samp[b].push_back(cur[b]);
            // Level changes once the last DEB synchronized samples all disagree
            flip = (k >= DEB);
            for (int j = k - DEB + 1; j <= k; j++) begin
                if (j >= 1 && synced_before(b, j) == deb_m[b]) flip = 1'b0;
            end
            new_ev = flip && !deb_m[b] && armed_m[b];
            if (k >= 3 && synced_before(b, k) == 1'b0) armed_m[b] = 1'b1;
            if (flip) deb_m[b] = !deb_m[b];
            ev_m[b] = new_ev;
        end
    endtask

    task automatic check(input string tag, input logic obs, input bit exp);
        nvec++;
        assert (obs === logic'(exp)) else begin
            nerr++;
            $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic dcheck(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rst) model_edge();
        else model_reset();
        check("ms", ms, ms_m);
        check("clr", clr, clr_m);
        check("running", running, st_m == RUN);
        check("paused", paused, st_m == PAUSED);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_running(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (running !== 1'b1 && n < 30);
    endtask

    task automatic wait_phase(input int ph);
        int n = 0;
        while (elapsed % DIV != ph && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic async_reset_check(input string tag);
        #2 rst = 1'b0;
        #1;
        dcheck({tag, "_ms"}, int'(ms), 0);
        dcheck({tag, "_clr"}, int'(clr), 0);
        dcheck({tag, "_running"}, int'(running), 0);
        dcheck({tag, "_paused"}, int'(paused), 0);
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;
        int nclr;
        int got [$];

        model_reset();
        steps(2);
        rst = 1'b1;
        steps(5);

        // 1: start press, latency and first three strobes
        btn_start = 1'b1;
        wait_running(n);
        dcheck("t1_start_latency", n, 6);
        for (int i = 1; i <= 31; i++) begin
            step();
            if (ms === 1'b1) got.push_back(i);
            if (i == 14) btn_start = 1'b0;
        end
        dcheck("t1_ms_count", got.size(), 3);
        for (int i = 0; i < 3; i++) begin
            dcheck("t1_ms_pos", (i < got.size()) ? got[i] : -1, 10 * (i + 1));
        end

        // 2: stop lands with div=4, resume strobes after the remaining 6 cycles
        wait_phase(9);
        btn_stop = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (paused !== 1'b1 && n < 30);
        dcheck("t2_stop_latency", n, 6);
        steps(3);
        btn_stop = 1'b0;
        steps(15);
        btn_start = 1'b1;
        wait_running(n);
        dcheck("t2_resume_latency", n, 6);
        m = 0;
        do begin
            step();
            m++;
        end while (ms !== 1'b1 && m < 20);
        dcheck("t2_resume_ms", m, 6);
        btn_start = 1'b0;
        steps(8);

        // 3: clear to IDLE, then a 2-cycle glitch on start must not register
        btn_clear = 1'b1;
        steps(8);
        btn_clear = 1'b0;
        steps(8);
        btn_start = 1'b1;
        steps(2);
        btn_start = 1'b0;
        steps(12);
        dcheck("t3_glitch_running", int'(running), 0);

        // 4: all three buttons together while running -> one clr, back to IDLE
        btn_start = 1'b1;
        wait_running(n);
        btn_start = 1'b0;
        steps(12);
        btn_start = 1'b1;
        btn_stop = 1'b1;
        btn_clear = 1'b1;
        nclr = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (clr === 1'b1) nclr++;
        end
        dcheck("t4_clr_pulses", nclr, 1);
        dcheck("t4_running", int'(running), 0);
        btn_start = 1'b0;
        btn_stop = 1'b0;
        btn_clear = 1'b0;
        steps(8);

        // 5: async reset mid-run with start held; needs release and re-press
        btn_start = 1'b1;
        wait_running(n);
        steps(7);
        async_reset_check("t5_reset");
        steps(2);
        rst = 1'b1;
        steps(20);
        dcheck("t5_held_no_restart", int'(running), 0);
        btn_start = 1'b0;
        steps(10);
        btn_start = 1'b1;
        wait_running(n);
        dcheck("t5_repress_latency", n, 6);

        // 6: start held 50 cycles, then stop lands at div==9
        steps(50);
        btn_start = 1'b0;
        wait_phase(4);
        btn_stop = 1'b1;
        steps(6);
        dcheck("t6_paused", int'(paused), 1);
        dcheck("t6_no_ms", int'(ms), 0);
        btn_stop = 1'b0;
        steps(8);
        btn_start = 1'b1;
        wait_running(n);
        step();
        dcheck("t6_resume_ms", int'(ms), 1);
        btn_start = 1'b0;
        steps(8);

        // Random button traffic with occasional asynchronous resets
        for (int r = 0; r < 120; r++) begin
            btn_start = 1'($urandom_range(0, 1));
            btn_stop = 1'($urandom_range(0, 3) == 0);
            btn_clear = 1'($urandom_range(0, 7) == 0);
            steps(int'($urandom_range(1, 8)));
            if ($urandom_range(0, 39) == 0) begin
                async_reset_check("rnd_reset");
                step();
                rst = 1'b1;
            end
        end
        btn_start = 1'b0;
        btn_stop = 1'b0;
        btn_clear = 1'b0;
        steps(10);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
